// File: rtl/osbm_pkg.sv
// -----------------------------------------------------------------------------
// osbm_pkg : shared definitions for the output-side switch manager (OSBM).
//   PORT       : highest input port index; the default port count is PORT+1
//   HEAD/TAIL  : packet-type codes carried on ptype (all other codes are body)
//   ASSERT/NEGATE : single-bit active/inactive levels
//   osbm_state_e  : IDLE / GRANT / XFER arbitration states
//   wrap_inc() : cyclic increment of a port index
// -----------------------------------------------------------------------------
package osbm_pkg;

  localparam int PORT = 3;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;

  localparam logic ASSERT = 1'b1;
  localparam logic NEGATE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    XFER  = 2'b10
  } osbm_state_e;

  // Next port index after idx, wrapping n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/osbm_if.sv
// -----------------------------------------------------------------------------
// osbm_if : request/grant and flit-lane signals between the input-side
// managers (master) and one output arbiter (slave).
//   req   [NPORT] : per-input request        (master -> slave)
//   vld           : flit present on lane      (master -> slave)
//   ptype [2]     : packet type of the flit   (master -> slave)
//   ack   [NPORT] : one-hot grant             (slave -> master)
//   sel           : granted input index       (slave -> master)
//   we            : write-enable to the link  (slave -> master)
//   err           : timeout abort pulse       (slave -> master)
//   busy          : grant outstanding/in flight (slave -> master)
// -----------------------------------------------------------------------------
interface osbm_if
  import osbm_pkg::*;
#(
  parameter int NPORT = PORT + 1
);

  localparam int SW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [NPORT-1:0] req;
  logic [NPORT-1:0] ack;
  logic [SW-1:0]    sel;
  logic             vld;
  logic [1:0]       ptype;
  logic             we;
  logic             err;
  logic             busy;

  modport master (
    output req, vld, ptype,
    input  ack, sel, we, err, busy
  );

  modport slave (
    input  req, vld, ptype,
    output ack, sel, we, err, busy
  );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick : cyclic priority search. Returns the first set bit of i_req at or
// after index i_ptr, wrapping NPORT-1 to 0.
//   i_req    [NPORT] : request vector
//   i_ptr    [W]     : search start index
//   o_winner [W]     : index of the winning request (0 when none)
//   o_any            : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import osbm_pkg::*;
#(
  parameter int NPORT = PORT + 1
) (
  input  logic [NPORT-1:0]                         i_req,
  input  logic [((NPORT > 1) ? $clog2(NPORT) : 1)-1:0] i_ptr,
  output logic [((NPORT > 1) ? $clog2(NPORT) : 1)-1:0] o_winner,
  output logic                                     o_any
);

  localparam int W = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [W:0] NP = (W+1)'(NPORT);

  logic [W:0]   w_sum;
  logic [W-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    o_winner = '0;
    o_any    = NEGATE;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (W+1)'(k);
      if (w_sum >= NP) begin
        w_sum = w_sum - NP;
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[W-1:0];
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_any    = ASSERT;
      end else begin
        o_winner = o_winner;
        o_any    = o_any;
      end
    end
  end

endmodule

// File: rtl/osbm.sv
// -----------------------------------------------------------------------------
// osbm : output-side switch manager. Arbitrates NPORT input ports for one
// output link with a round-robin pointer, grants the winner for one cycle,
// then forwards its flits until TAIL or until TMO consecutive idle cycles.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : osbm_if.slave (req/vld/ptype in, ack/sel/we/err/busy out)
// -----------------------------------------------------------------------------
module osbm
  import osbm_pkg::*;
#(
  parameter int NPORT = PORT + 1,
  parameter int TMO   = 16
) (
  input  logic   clk,
  input  logic   rst,
  osbm_if.slave  bus
);

  localparam int SW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0]    TMO_LAST = CW'(TMO - 1);
  localparam logic [NPORT-1:0] ONE_HOT0 = NPORT'(1);

  osbm_state_e   r_state, w_state_nxt;
  logic [SW-1:0] r_ptr, w_ptr_nxt;
  logic [SW-1:0] r_sel, w_sel_nxt;
  logic [CW-1:0] r_idle, w_idle_nxt;
  logic          r_err, w_err_nxt;

  logic [SW-1:0] w_winner;
  logic          w_any;
  logic          w_tail;
  logic [SW-1:0] w_ptr_adv;

  rr_pick #(.NPORT(NPORT)) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_tail    = bus.vld & (bus.ptype == TAIL);
  // Pointer moves just past the port that owned the link.
  assign w_ptr_adv = SW'(wrap_inc(int'(r_sel), NPORT));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_idle  <= '0;
      r_err   <= NEGATE;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_idle  <= w_idle_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic; req is only looked at while IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_idle_nxt  = r_idle;
    w_err_nxt   = NEGATE;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_sel_nxt   = w_winner;
          w_idle_nxt  = '0;
          w_state_nxt = GRANT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        // A dropped req does not cancel the grant; the timeout recovers.
        if (w_tail) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = w_ptr_adv;
        end else begin
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_tail) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = w_ptr_adv;
          w_idle_nxt  = '0;
        end else if (bus.vld) begin
          w_idle_nxt  = '0;
        end else if (r_idle == TMO_LAST) begin
          // This is the TMO-th consecutive idle cycle: abort the packet.
          w_state_nxt = IDLE;
          w_ptr_nxt   = w_ptr_adv;
          w_idle_nxt  = '0;
          w_err_nxt   = ASSERT;
        end else begin
          w_idle_nxt  = r_idle + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
        w_sel_nxt   = '0;
        w_idle_nxt  = '0;
      end
    endcase
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.ack  = (r_state == GRANT) ? (ONE_HOT0 << r_sel) : '0;
  assign bus.sel  = r_sel;
  assign bus.err  = r_err;
  // The lane strobe passes through only while the link is owned.
  assign bus.we   = bus.vld & bus.busy;

endmodule

// File: tb/tb_osbm.sv
module tb_osbm;
  import osbm_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   m_ptr;

  osbm_if #(.NPORT(4)) bus ();

  osbm #(.NPORT(4), .TMO(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first requesting port scanning p, p+1, ... modulo 4.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (((r >> ((p + k) % 4)) & 4'd1) != 4'd0) return (p + k) % 4;
    end
    return -1;
  endfunction

  // One packet from an idle link. rnd enables gaps and req jitter.
  task automatic run_packet(input logic [3:0] r, input int nflits, input bit tmo,
                            input bit drop_req, input bit rnd);
    int w;
    int f;
    int gaps;
    bit last;
    bus.req   = r;
    bus.vld   = 1'b0;
    bus.ptype = 2'b00;
    #1;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_ack", 32'(bus.ack), 32'd0);
    chk("idle_err", 32'(bus.err), 32'd0);
    w = pick(r, m_ptr);
    tick();
    chk("grant_ack", 32'(bus.ack), 32'(4'd1 << w));
    chk("grant_sel", 32'(bus.sel), 32'(w));
    chk("grant_busy", 32'(bus.busy), 32'd1);
    if (drop_req) bus.req = 4'b0000;
    if (tmo) begin
      for (int c = 0; c < 17; c++) begin
        bus.vld = 1'b0;
        if (rnd) bus.req = 4'($urandom_range(0, 15));
        #1;
        chk("tmo_we", 32'(bus.we), 32'd0);
        tick();
        if (c < 16) begin
          chk("tmo_busy", 32'(bus.busy), 32'd1);
          chk("tmo_err_early", 32'(bus.err), 32'd0);
          chk("tmo_ack", 32'(bus.ack), 32'd0);
          chk("tmo_sel", 32'(bus.sel), 32'(w));
        end
      end
      chk("tmo_err", 32'(bus.err), 32'd1);
      chk("tmo_idle", 32'(bus.busy), 32'd0);
      bus.req = 4'b0000;
      tick();
      chk("tmo_err_pulse", 32'(bus.err), 32'd0);
    end else begin
      f    = 0;
      gaps = 0;
      while (f < nflits) begin
        last = 1'b0;
        if (rnd && gaps < 3 && $urandom_range(0, 3) == 0) begin
          bus.vld = 1'b0;
          bus.ptype = 2'($urandom_range(0, 3));
          gaps++;
        end else begin
          bus.vld = 1'b1;
          gaps = 0;
          if (f == nflits - 1) begin
            bus.ptype = TAIL;
            last = 1'b1;
          end else if (f == 0) begin
            bus.ptype = HEAD;
          end else begin
            bus.ptype = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
          end
          f++;
        end
        if (rnd) bus.req = 4'($urandom_range(0, 15));
        #1;
        chk("xfer_we", 32'(bus.we), 32'(bus.vld));
        tick();
        chk("xfer_ack", 32'(bus.ack), 32'd0);
        chk("xfer_err", 32'(bus.err), 32'd0);
        if (last) begin
          chk("tail_idle", 32'(bus.busy), 32'd0);
        end else begin
          chk("xfer_busy", 32'(bus.busy), 32'd1);
          chk("xfer_sel", 32'(bus.sel), 32'(w));
        end
      end
    end
    bus.vld = 1'b0;
    m_ptr = (w + 1) % 4;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_ptr     = 0;
    rst       = 1'b0;
    bus.req   = 4'b0000;
    bus.vld   = 1'b0;
    bus.ptype = 2'b00;
    tick();
    tick();
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    rst = 1'b1;
    tick();

    // vld in IDLE with no request must not write.
    bus.vld   = 1'b1;
    bus.ptype = TAIL;
    #1;
    chk("idle_vld_we", 32'(bus.we), 32'd0);
    tick();
    chk("idle_vld_busy", 32'(bus.busy), 32'd0);
    bus.vld = 1'b0;

    // All ports requesting: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) run_packet(4'b1111, 3, 1'b0, 1'b0, 1'b0);
    // Single port 2 (ptr now 1).
    run_packet(4'b0100, 3, 1'b0, 1'b0, 1'b0);
    // ptr=3 with ports 0 and 3: 3 first, then wrap to 0.
    run_packet(4'b1001, 2, 1'b0, 1'b0, 1'b0);
    run_packet(4'b1001, 2, 1'b0, 1'b0, 1'b0);
    // Single-flit packet: TAIL in GRANT.
    run_packet(4'b0010, 1, 1'b0, 1'b0, 1'b0);
    // Timeout abort.
    run_packet(4'b1000, 0, 1'b1, 1'b0, 1'b0);
    // Request dropped during GRANT.
    run_packet(4'b0001, 3, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of port 2's packet.
    bus.req = 4'b0100;
    tick();
    chk("mid_grant", 32'(bus.ack), 32'h4);
    bus.vld = 1'b1; bus.ptype = HEAD;
    tick();
    bus.ptype = 2'b00;
    tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(bus.ack), 32'd0);
    chk("mid_rst_we", 32'(bus.we), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    chk("mid_rst_sel", 32'(bus.sel), 32'd0);
    bus.vld = 1'b0;
    bus.req = 4'b0000;
    tick();
    rst   = 1'b1;
    m_ptr = 0;
    tick();
    run_packet(4'b0110, 2, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(1, 15));
      run_packet(r, int'($urandom_range(1, 6)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osbm.md
OSBM -- requirements
Module: osbm

Interface
REQ-001 SHALL have parameter NPORT, default `PORT+1: number of input ports competing for this output.
REQ-002 SHALL have parameter TMO, default 16: idle-cycle limit during a transfer before abort.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NPORT  bit i = input port i requests this output (driven by that port's input-side manager).
REQ-006 ack  output  NPORT  one-hot grant; bit i acknowledges input port i.
REQ-007 sel  output  $clog2(NPORT)  index of the granted input; drives the output data mux.
REQ-008 vld  input  1  granted input's read-enable: a flit is presented on the muxed lane this cycle.
REQ-009 ptype  input  2  packet type of the muxed flit (`HEAD, `TAIL, others = body), qualified by vld.
REQ-010 we  output  1  write-enable to the output link/buffer.
REQ-011 err  output  1  one-cycle pulse on timeout abort.
REQ-012 busy  output  1  high while a grant is outstanding or a packet is in flight.

Function
REQ-013 SHALL implement states IDLE, GRANT, XFER (enum in shared package).
REQ-014 IDLE: if req != 0, SHALL register winner w = first set bit of req at or after ptr (cyclic), load sel = w, go to GRANT; else stay.
REQ-015 GRANT: SHALL assert ack[w] for exactly this one cycle, then go to XFER; ack SHALL be 0 in every other state.
REQ-016 XFER: SHALL hold sel = w; SHALL ignore req (including req[w]) until return to IDLE.
REQ-017 we SHALL equal vld in GRANT and XFER, and SHALL be 0 in IDLE regardless of vld.
REQ-018 vld=1 with ptype=`TAIL in GRANT or XFER SHALL go to IDLE next cycle and load ptr = (w+1) mod NPORT; that flit still gets we=1.
REQ-019 Grant-to-grant latency SHALL be at least 2 cycles after the TAIL cycle (IDLE, then GRANT).
REQ-020 In XFER, an idle counter SHALL count consecutive cycles with vld=0 and clear on vld=1; reaching TMO SHALL go to IDLE, pulse err, advance ptr as on TAIL.
REQ-021 Idle counter SHALL be wide enough for TMO without wrap; SHALL clear on entry to GRANT.
REQ-022 ptr wrap: index NPORT-1 SHALL wrap to 0 in both search and update.
REQ-023 A req bit dropping while in GRANT SHALL NOT cancel the grant; the FSM proceeds to XFER (timeout recovers).
REQ-024 busy SHALL be 1 in GRANT and XFER, 0 in IDLE.
REQ-025 All outputs SHALL be registered or decoded from registered state only; no combinational path from req to ack.

Reset
REQ-026 rst low SHALL immediately force state=IDLE, ptr=0, sel=0, idle counter=0, err=0; hence ack=0, we=0, busy=0.
REQ-027 rst asserted mid-packet SHALL abort the packet without err pulse; first grant after release searches from index 0.

Structure
REQ-028 State enum and packet-type codes (`HEAD, `TAIL, `ASSERT, `NEGATE) SHALL come from the shared switch header/package (sw.vh).
REQ-029 The cyclic priority search SHALL be a sub-module rr_pick (inputs req, ptr; output winner index, any).

Verification
REQ-030 NPORT=4, req=4'b0100 from reset -> GRANT next cycle, ack=4'b0100 for one cycle, sel=2.
REQ-031 req=4'b1111 held, each packet HEAD,body,TAIL with vld=1 -> grant order 0,1,2,3,0; ack exactly one-hot each time.
REQ-032 ptr=3, req=4'b1001 -> winner 3; after its TAIL, ptr=0 and winner 0 (wrap).
REQ-033 granted, vld=0 for 16 cycles in XFER -> err=1 for one cycle, state IDLE, we never asserted.
REQ-034 rst low during XFER of port 2 -> ack/we/busy=0 same cycle; after release with req=4'b0110 -> winner 1.
REQ-035 vld=1 in IDLE with req=0 -> we=0; single-flit packet with ptype=`TAIL in GRANT -> we=1, IDLE next cycle.
